shot_evaluator: RTL and testbench

- Produces the single-cycle HIT and FAIL pulses that the seven-segment display block consumes.
- Synchronizes and debounces the raw fire button, and captures the target coordinates from the switches.
- Evaluates each shot against a 4x4 ship map and tracks which cells have already been fired on.
- Reports per-game status: shot count, hit count, all ships sunk.

---
 rtl/shot_evaluator.sv | 170 +++++++++++++++++
 tb/tb_shot_evaluator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_evaluator.sv
// shot_evaluator: debounced fire button, 4x4 shot evaluation and game status.
// Ports: clk, rst_n (async active-low), fire_btn (raw), row_sw/col_sw (target),
//   ship_map (occupancy, bit = row*4+col), new_game (sync clear);
//   HIT/FAIL (one-cycle pulses), all_sunk, out_of_shots, shot_count, hit_count.
// Optional: define SHOT_LIMIT_EN to enforce a MAX_SHOTS budget per game.
module shot_evaluator #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int MAX_SHOTS       = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fire_btn,
   input  logic [1:0]  row_sw,
   input  logic [1:0]  col_sw,
   input  logic [15:0] ship_map,
   input  logic        new_game,
   output logic        HIT,
   output logic        FAIL,
   output logic        all_sunk,
   output logic        out_of_shots,
   output logic [7:0]  shot_count,
   output logic [4:0]  hit_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < 2 || MAX_SHOTS < 1 || MAX_SHOTS > 255) begin : g_param_chk
      $error("shot_evaluator: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      REPORT,
      WAIT_RELEASE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic          sync1;
   logic          sync2;
   logic          btn_db;
   logic [CW-1:0] db_cnt;
   logic [3:0]    idx;
   logic [15:0]   shot_mask;
   logic [15:0]   mask_nxt;
   logic          capture;
   logic          eval;
   logic          hit_cond;

   // Two-flop synchronizer followed by a run-length debouncer: the level
   // only flips once the synchronized value has disagreed for a full run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         btn_db <= 1'b0;
         db_cnt <= '0;
      end else begin
         sync1 <= fire_btn;
         sync2 <= sync1;
         if (sync2 == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      eval      = 1'b0;
      unique case (state)
         IDLE: begin
            if (btn_db) begin
               if (!all_sunk && !out_of_shots) begin
                  state_nxt = EVAL;
                  capture   = 1'b1;
               end else begin
                  state_nxt = WAIT_RELEASE;
               end
            end
         end
         EVAL: begin
            state_nxt = REPORT;
            eval      = 1'b1;
         end
         REPORT: state_nxt = WAIT_RELEASE;
         WAIT_RELEASE: begin
            if (!btn_db) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A held button must not fire straight into a fresh game.
      if (new_game) begin
         state_nxt = WAIT_RELEASE;
         capture   = 1'b0;
         eval      = 1'b0;
      end
   end

   assign hit_cond = ship_map[idx] & ~shot_mask[idx];

   always_comb begin
      mask_nxt = shot_mask;
      if (new_game)  mask_nxt = '0;
      else if (eval) mask_nxt = shot_mask | (16'h0001 << idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         shot_mask  <= '0;
         HIT        <= 1'b0;
         FAIL       <= 1'b0;
         shot_count <= '0;
         hit_count  <= '0;
         all_sunk   <= 1'b0;
      end else begin
         if (capture) idx <= {row_sw, col_sw};
         shot_mask <= mask_nxt;
         HIT       <= eval & hit_cond;
         FAIL      <= eval & ~hit_cond;
         if (new_game) begin
            shot_count <= '0;
            hit_count  <= '0;
         end else if (eval) begin
            if (shot_count != 8'hFF) shot_count <= shot_count + 1'b1;
            if (hit_cond)            hit_count  <= hit_count + 1'b1;
         end
         // Built from the next mask so it rises with the final HIT pulse.
         all_sunk <= !new_game && (ship_map != '0)
                     && ((ship_map & ~mask_nxt) == '0);
      end
   end

`ifdef SHOT_LIMIT_EN
   logic [7:0] shots_left;
   logic [7:0] left_nxt;

   always_comb begin
      left_nxt = shots_left;
      if (new_game)                       left_nxt = 8'(MAX_SHOTS);
      else if (eval && shots_left != '0)  left_nxt = shots_left - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shots_left   <= 8'(MAX_SHOTS);
         out_of_shots <= 1'b0;
      end else begin
         shots_left   <= left_nxt;
         out_of_shots <= !new_game && (left_nxt == '0);
      end
   end
`else
   assign out_of_shots = 1'b0;
`endif

endmodule

// File: tb/tb_shot_evaluator.sv
// tb_shot_evaluator: directed plus randomized bench for shot_evaluator,
// compared every cycle against a behavioural game model.
module tb_shot_evaluator;

   localparam int DB   = 4;
   localparam int MAXS = 3;

   logic        clk;
   logic        rst_n;
   logic        fire_btn;
   logic [1:0]  row_sw;
   logic [1:0]  col_sw;
   logic [15:0] ship_map;
   logic        new_game;
   logic        HIT;
   logic        FAIL;
   logic        all_sunk;
   logic        out_of_shots;
   logic [7:0]  shot_count;
   logic [4:0]  hit_count;

   shot_evaluator #(.DEBOUNCE_CYCLES(DB), .MAX_SHOTS(MAXS)) dut (
      .clk(clk), .rst_n(rst_n), .fire_btn(fire_btn),
      .row_sw(row_sw), .col_sw(col_sw), .ship_map(ship_map),
      .new_game(new_game), .HIT(HIT), .FAIL(FAIL),
      .all_sunk(all_sunk), .out_of_shots(out_of_shots),
      .shot_count(shot_count), .hit_count(hit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_pulse  = 0;
   int n_hitp   = 0;
   int last_pulse = -1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Behavioural model: button seen two edges late, debounced by run
   // length, then one shot per accepted press with pulse two cycles later.
   bit          m_sa, m_sb, m_db;
   int          m_run;
   logic [15:0] m_mask;
   int          m_shots, m_hits, m_timer, m_left;
   bit          m_wait, m_hit, m_fail, m_sunk, m_out;
   logic [3:0]  m_idx;

   always @(posedge clk or negedge rst_n) begin
      bit db_old, sb_old, hc;
      if (!rst_n) begin
         m_sa = 0; m_sb = 0; m_db = 0; m_run = 0;
         m_mask = '0; m_shots = 0; m_hits = 0; m_timer = 0;
         m_left = MAXS; m_wait = 0; m_hit = 0; m_fail = 0;
         m_sunk = 0; m_out = 0; m_idx = '0;
      end else begin
         cyc++;
         db_old = m_db;
         sb_old = m_sb;
         m_sb = m_sa;
         m_sa = fire_btn;
         if (sb_old != m_db) begin
            m_run++;
            if (m_run == DB) begin
               m_db  = sb_old;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_hit = 0;
         m_fail = 0;
         if (new_game) begin
            m_mask = '0; m_shots = 0; m_hits = 0;
            m_timer = 0; m_wait = 1; m_left = MAXS;
         end else if (m_timer == 2) begin
            hc = ship_map[m_idx] && !m_mask[m_idx];
            m_mask[m_idx] = 1'b1;
            if (m_shots < 255) m_shots++;
            if (hc) m_hits++;
            m_hit = hc;
            m_fail = !hc;
            if (m_left > 0) m_left--;
            m_timer = 1;
         end else if (m_timer == 1) begin
            m_timer = 0;
            m_wait = 1;
         end else if (m_wait) begin
            if (!db_old) m_wait = 0;
         end else if (db_old) begin
            if (m_sunk || m_out) begin
               m_wait = 1;
            end else begin
               m_idx = {row_sw, col_sw};
               m_timer = 2;
            end
         end
         m_sunk = !new_game && ship_map != 0 && (ship_map & ~m_mask) == 0;
`ifdef SHOT_LIMIT_EN
         m_out = !new_game && m_left == 0;
`else
         m_out = 0;
`endif
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("HIT", 32'(HIT), 32'(m_hit));
         check("FAIL_out", 32'(FAIL), 32'(m_fail));
         check("all_sunk", 32'(all_sunk), 32'(m_sunk));
         check("out_of_shots", 32'(out_of_shots), 32'(m_out));
         check("shot_count", 32'(shot_count), 32'(m_shots));
         check("hit_count", 32'(hit_count), 32'(m_hits));
         if (HIT || FAIL) begin
            n_pulse++;
            last_pulse = cyc;
         end
         if (HIT) n_hitp++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   int c0;

   task automatic press(input int r, input int c, input int hi);
      @(negedge clk);
      row_sw = 2'(r);
      col_sw = 2'(c);
      fire_btn = 1'b1;
      c0 = cyc;
      cycles(hi);
      fire_btn = 1'b0;
      cycles(12);
   endtask

   task automatic start_game(input logic [15:0] map);
      @(negedge clk);
      ship_map = map;
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      cycles(2);
   endtask

   int p0, h0;
   bit found;

   initial begin
      rst_n = 1'b0; fire_btn = 0; row_sw = 0; col_sw = 0;
      ship_map = 16'h0001; new_game = 0;
      cycles(3);
      check("rst_HIT", 32'(HIT), 0);
      check("rst_shot_count", 32'(shot_count), 0);
      rst_n = 1'b1;
      cycles(2);

      // single hit sinks a one-cell fleet
      p0 = n_pulse; h0 = n_hitp;
      press(0, 0, 10);
      check("t1_pulses", n_pulse - p0, 1);
      check("t1_hits", n_hitp - h0, 1);
      check("t1_latency", last_pulse - c0, 8);
      check("t1_hit_count", 32'(hit_count), 1);
      check("t1_shot_count", 32'(shot_count), 1);
      check("t1_all_sunk", 32'(all_sunk), 1);
      p0 = n_pulse;
      press(1, 1, 10);
      check("t1_sunk_no_fire", n_pulse - p0, 0);

      // hit, repeat, miss
      start_game(16'h8001);
      p0 = n_pulse; h0 = n_hitp;
      press(3, 3, 10);
      press(3, 3, 10);
      press(1, 1, 10);
      check("t3_pulses", n_pulse - p0, 3);
      check("t3_hits", n_hitp - h0, 1);
      check("t3_hit_count", 32'(hit_count), 1);
      check("t3_shot_count", 32'(shot_count), 3);
      check("t3_all_sunk", 32'(all_sunk), 0);
`ifdef SHOT_LIMIT_EN
      check("t3_out", 32'(out_of_shots), 1);
`else
      check("t3_out", 32'(out_of_shots), 0);
`endif

      // bounce then clean hold, and a short glitch
      start_game(16'h8001);
      p0 = n_pulse;
      for (int i = 0; i < 10; i++) begin
         fire_btn = 1'b1; cycles(2);
         fire_btn = 1'b0; cycles(2);
      end
      fire_btn = 1'b1; cycles(10);
      fire_btn = 1'b0; cycles(12);
      check("t2_bounce_pulses", n_pulse - p0, 1);
      p0 = n_pulse;
      press(0, 1, 3);
      check("t2_glitch_pulses", n_pulse - p0, 0);

      // long hold fires once
      start_game(16'h0F0F);
      p0 = n_pulse;
      press(0, 2, 1000);
      check("t4_hold_pulses", n_pulse - p0, 1);
      press(2, 0, 10);
      check("t4_second_pulse", n_pulse - p0, 2);

`ifdef SHOT_LIMIT_EN
      start_game(16'hFFFF);
      h0 = n_hitp; p0 = n_pulse;
      press(0, 0, 10);
      press(0, 1, 10);
      press(0, 2, 10);
      check("t5_hits", n_hitp - h0, 3);
      check("t5_out", 32'(out_of_shots), 1);
      press(0, 3, 10);
      check("t5_no_fire", n_pulse - p0, 3);
      start_game(16'hFFFF);
      check("t5_ng_out", 32'(out_of_shots), 0);
      check("t5_ng_shots", 32'(shot_count), 0);
      check("t5_ng_hits", 32'(hit_count), 0);
      h0 = n_hitp;
      press(1, 0, 10);
      check("t5_next_hit", n_hitp - h0, 1);
`endif

      // reset while a shot is in EVAL
      start_game(16'hFFFF);
      row_sw = 2; col_sw = 2;
      fire_btn = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk);
         #1;
         if (m_timer == 2) found = 1;
      end
      check("t6_reached_eval", 32'(found), 1);
      #2 rst_n = 1'b0;
      fire_btn = 1'b0;
      #1;
      check("t6_HIT", 32'(HIT), 0);
      check("t6_FAIL", 32'(FAIL), 0);
      check("t6_all_sunk", 32'(all_sunk), 0);
      check("t6_out", 32'(out_of_shots), 0);
      check("t6_shots", 32'(shot_count), 0);
      check("t6_hits", 32'(hit_count), 0);
      cycles(2);
      rst_n = 1'b1;
      p0 = n_pulse;
      cycles(20);
      check("t6_no_pulse", n_pulse - p0, 0);
      press(2, 2, 10);
      check("t6_fresh_press", n_pulse - p0, 1);
      check("t6_hit_count", 32'(hit_count), 1);

      // randomized play
      for (int s = 0; s < 600; s++) begin
         @(negedge clk);
         if ($urandom_range(0, 39) == 0) begin
            ship_map = ($urandom_range(0, 7) == 0) ? 16'h0 :
                       16'($urandom & $urandom & $urandom);
            new_game = 1'b1;
            @(negedge clk);
            new_game = 1'b0;
         end
         fire_btn = 1'($urandom_range(0, 1));
         for (int k = $urandom_range(1, 12); k > 0; k--) begin
            row_sw = 2'($urandom_range(0, 3));
            col_sw = 2'($urandom_range(0, 3));
            @(negedge clk);
         end
      end
      fire_btn = 1'b0;
      cycles(20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
